arr_feeder: RTL and testbench



---
 rtl/arr_feeder.sv | 135 +++++++++++++
 tb/tb_arr_feeder.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/arr_feeder.sv
// Skewing feeder for the 4x4 systolic array: lane k is delayed k extra cycles, zeros are
// padded after the last beat so the array drains. Optional beat counter: ARR_FEED_CNT_EN.
module arr_feeder_lane #(
  parameter int DW    = 8,
  parameter int DEPTH = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          adv,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout
);
  logic [DEPTH-1:0][DW-1:0] sr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr <= '0;
    end else if (adv) begin
      for (int i = DEPTH-1; i > 0; i--) sr[i] <= sr[i-1];
      sr[0] <= din;
    end
  end

  assign dout = sr[DEPTH-1];
endmodule

module arr_feeder #(
  parameter int DW    = 8,
  parameter int DRAIN = 7
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          in_last,
  input  logic [4*DW-1:0] w_vec,
  input  logic [4*DW-1:0] a_vec,
  output logic [DW-1:0] w1_out,
  output logic [DW-1:0] w2_out,
  output logic [DW-1:0] w3_out,
  output logic [DW-1:0] w4_out,
  output logic [DW-1:0] a1_out,
  output logic [DW-1:0] a2_out,
  output logic [DW-1:0] a3_out,
  output logic [DW-1:0] a4_out,
  output logic          hold,
  output logic          busy,
  output logic          done
`ifdef ARR_FEED_CNT_EN
  ,
  output logic [15:0]   beat_cnt
`endif
);
  localparam int NUM_LANES = 4;
  localparam int CW = (DRAIN > 1) ? $clog2(DRAIN) : 1;

  typedef enum logic [1:0] {IDLE, FEED, DRN, DONE} state_t;

  state_t                          state;
  logic [CW-1:0]                   drain_cnt;
  logic                            accept, adv;
  logic [4*DW-1:0]                 din_w, din_a;
  logic [NUM_LANES-1:0][DW-1:0]    w_lane, a_lane;

  // in_ready is forced low while rst is held so nothing is taken during reset
  assign in_ready = !rst && (state == IDLE || state == FEED);
  assign accept   = in_valid && in_ready;
  assign adv      = accept || (state == DRN);
  // array and skew line freeze on exactly the same cycles
  assign hold     = !adv;
  assign din_w    = accept ? w_vec : '0;
  assign din_a    = accept ? a_vec : '0;

  for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
    arr_feeder_lane #(.DW(DW), .DEPTH(k+1)) u_w (
      .clk(clk), .rst(rst), .adv(adv), .din(din_w[k*DW +: DW]), .dout(w_lane[k])
    );
    arr_feeder_lane #(.DW(DW), .DEPTH(k+1)) u_a (
      .clk(clk), .rst(rst), .adv(adv), .din(din_a[k*DW +: DW]), .dout(a_lane[k])
    );
  end

  assign w1_out = w_lane[0];
  assign w2_out = w_lane[1];
  assign w3_out = w_lane[2];
  assign w4_out = w_lane[3];
  assign a1_out = a_lane[0];
  assign a2_out = a_lane[1];
  assign a3_out = a_lane[2];
  assign a4_out = a_lane[3];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      drain_cnt <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          busy <= 1'b1;
          if (in_last) begin
            state     <= DRN;
            drain_cnt <= CW'(DRAIN-1);
          end else begin
            state <= FEED;
          end
        end
        FEED: if (accept && in_last) begin
          state     <= DRN;
          drain_cnt <= CW'(DRAIN-1);
        end
        DRN: if (drain_cnt == '0) begin
          state <= DONE;
          busy  <= 1'b0;
          done  <= 1'b1;
        end else begin
          drain_cnt <= drain_cnt - 1'b1;
        end
        default: begin
          state <= IDLE;
          done  <= 1'b0;
        end
      endcase
    end
  end

`ifdef ARR_FEED_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                           beat_cnt <= '0;
    else if (accept && state == IDLE)  beat_cnt <= 16'd1;
    else if (accept && beat_cnt != 16'hFFFF) beat_cnt <= beat_cnt + 16'd1;
  end
`endif
endmodule

// File: tb/tb_arr_feeder.sv
// Bench for arr_feeder: directed plus randomized tiles checked against a column-history model.
module tb_arr_feeder;
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_last;
  logic        in_ready;
  logic [31:0] w_vec, a_vec;
  logic [7:0]  w1_out, w2_out, w3_out, w4_out, a1_out, a2_out, a3_out, a4_out;
  logic        hold, busy, done;
`ifdef ARR_FEED_CNT_EN
  logic [15:0] beat_cnt;
`endif

  arr_feeder #(.DW(8), .DRAIN(7)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
    .w_vec(w_vec), .a_vec(a_vec),
    .w1_out(w1_out), .w2_out(w2_out), .w3_out(w3_out), .w4_out(w4_out),
    .a1_out(a1_out), .a2_out(a2_out), .a3_out(a3_out), .a4_out(a4_out),
    .hold(hold), .busy(busy), .done(done)
`ifdef ARR_FEED_CNT_EN
    , .beat_cnt(beat_cnt)
`endif
  );

  always #5 clk = ~clk;

  logic [3:0][7:0] wo, ao;
  assign wo = {w4_out, w3_out, w2_out, w1_out};
  assign ao = {a4_out, a3_out, a2_out, a1_out};

  int tests = 0;
  int fails = 0;

  // Model: history of columns fed into the array (newest first); lane k shows
  // lane k of the column fed k+1 advances ago. mode: 0 idle, 1 feed, 2 drain, 3 done.
  logic [31:0] hw[$], ha[$];
  int          mode = 0;
  int          dleft = 0;
  logic [15:0] ecnt = 0;

  function automatic logic [7:0] lane_exp(input bit isw, input int k);
    logic [31:0] e;
    e = 32'h0;
    if (isw && hw.size() > k) e = hw[k];
    if (!isw && ha.size() > k) e = ha[k];
    return e[k*8 +: 8];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    logic acc;
    acc = (mode <= 1) && in_valid && !rst;
    chk("in_ready", 32'(in_ready), 32'((mode <= 1) && !rst));
    chk("hold", 32'(hold), 32'(!(acc || mode == 2)));
    chk("busy", 32'(busy), 32'(mode == 1 || mode == 2));
    chk("done", 32'(done), 32'(mode == 3));
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("w%0d_out", k+1), 32'(wo[k]), 32'(lane_exp(1'b1, k)));
      chk($sformatf("a%0d_out", k+1), 32'(ao[k]), 32'(lane_exp(1'b0, k)));
    end
`ifdef ARR_FEED_CNT_EN
    chk("beat_cnt", 32'(beat_cnt), 32'(ecnt));
`endif
  endtask

  task automatic clear_model();
    hw.delete(); ha.delete();
    mode = 0; dleft = 0; ecnt = 0;
  endtask

  // Called at posedge+1; drives inputs, checks at negedge, advances model at posedge.
  task automatic cyc(input logic v, input logic l, input logic [31:0] w, input logic [31:0] a);
    in_valid = v; in_last = l; w_vec = w; a_vec = a;
    @(negedge clk);
    check_all();
    @(posedge clk);
    if (mode <= 1 && v) begin
      hw.push_front(w); ha.push_front(a);
      if (mode == 0) ecnt = 16'd1;
      else if (ecnt != 16'hFFFF) ecnt = ecnt + 16'd1;
      if (l) begin mode = 2; dleft = 7; end
      else mode = 1;
    end else if (mode == 2) begin
      hw.push_front(32'h0); ha.push_front(32'h0);
      dleft--;
      if (dleft == 0) mode = 3;
    end else if (mode == 3) begin
      mode = 0;
    end
    while (hw.size() > 4) begin void'(hw.pop_back()); void'(ha.pop_back()); end
    #1;
  endtask

  task automatic mid_reset();
    #2;
    in_valid = 1'b1;
    rst = 1'b1;
    #1;
    clear_model();
    check_all();
    @(posedge clk);
    #1;
    rst = 1'b0;
    in_valid = 1'b0;
  endtask

  task automatic settle(input bit rnd_valid);
    for (int g = 0; g < 20 && mode != 0; g++)
      cyc(rnd_valid ? 1'($urandom_range(0, 1)) : 1'b0, 1'($urandom_range(0, 1)), $urandom, $urandom);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b1; in_last = 1'b0; w_vec = 32'hDEADBEEF; a_vec = 32'hCAFEF00D;
    @(posedge clk);
    #1;
    check_all();
    rst = 1'b0;

    // skew: lanes {4,3,2,1} scaled by beat index, continuous valid
    for (int b = 1; b <= 4; b++)
      cyc(1'b1, b == 4, {8'(4*b), 8'(3*b), 8'(2*b), 8'(b)}, $urandom);
    settle(1'b0);
    cyc(1'b0, 1'b0, 32'h0, 32'h0);

    // 5-beat tile with two bubble cycles mid-tile
    for (int b = 0; b < 5; b++) begin
      if (b == 2) begin
        cyc(1'b0, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF);
        cyc(1'b0, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF);
      end
      cyc(1'b1, b == 4, $urandom, $urandom);
    end
    settle(1'b0);
    // next tile restarts the count
    cyc(1'b1, 1'b0, $urandom, $urandom);
    cyc(1'b1, 1'b1, $urandom, $urandom);
    // source holds valid through drain/done; next beat taken only in IDLE
    settle(1'b0);
    cyc(1'b1, 1'b0, 32'h01020304, 32'h05060708);
    for (int g = 0; g < 5; g++) cyc(1'b1, 1'b1, 32'h11111111, 32'h22222222);
    settle(1'b0);
    cyc(1'b1, 1'b1, 32'h0A0B0C0D, 32'h0E0F1011);
    settle(1'b0);

    // single beat, then reset during drain: no done afterwards
    cyc(1'b1, 1'b1, $urandom, 32'h44332211);
    for (int g = 0; g < 4; g++) cyc(1'b0, 1'b0, 32'h0, 32'h0);
    mid_reset();
    for (int g = 0; g < 8; g++) cyc(1'b0, 1'b0, 32'h0, 32'h0);

    // reset mid-feed with nonzero lanes
    for (int b = 0; b < 3; b++) cyc(1'b1, 1'b0, $urandom | 32'h01010101, $urandom | 32'h01010101);
    mid_reset();
    cyc(1'b0, 1'b0, 32'h0, 32'h0);

    // randomized tiles with bubbles, stray in_last, and valid during drain
    for (int t = 0; t < 12; t++) begin
      int nb;
      nb = $urandom_range(1, 6);
      for (int b = 0; b < nb; b++) begin
        while ($urandom_range(0, 2) == 0) cyc(1'b0, 1'($urandom_range(0, 1)), $urandom, $urandom);
        cyc(1'b1, b == nb-1, $urandom, $urandom);
      end
      settle(1'b1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
